output_compare: RTL and testbench
=================================

OUTPUT_COMPARE -- requirements
Module: output_compare

Interface
REQ-001 SHALL have parameter W, default 8, the sample width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, the reference alignment FIFO depth (power of 2, 2..16).
REQ-003 SHALL have parameter NSAMP, default 20000, the number of compared samples per run.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: a pulse in IDLE or DONE begins a run.
REQ-007 SHALL have port stop_on_err, input, 1 bit: when 1, the first mismatch halts the run.
REQ-008 SHALL have ports ref_valid (input, 1) and ref_data (input, W): the reference-model output stream.
REQ-009 SHALL have ports dut_valid (input, 1) and dut_data (input, W): the design-under-test output stream.
REQ-010 SHALL have port busy, output, 1 bit: high in RUN.
REQ-011 SHALL have ports pass and fail, output, 1 bit each: the sticky verdict.
REQ-012 SHALL have port mismatch_cnt, output, 16 bits: saturating mismatch count.
REQ-013 SHALL have ports first_idx (output, 16), first_ref (output, W) and first_dut (output, W): capture of the first mismatch.
REQ-014 SHALL have port ovf, output, 1 bit: sticky flag for FIFO overflow or underflow.

Function
REQ-015 SHALL implement the FSM IDLE -> RUN on start; RUN -> DONE when the compared count reaches NSAMP; RUN -> HALT on ovf, or on a mismatch while stop_on_err=1; DONE/HALT -> RUN on start.
REQ-016 SHALL, on the start transition, clear the FIFO, the compared count, mismatch_cnt, first_*, ovf, pass and fail in the same cycle.
REQ-017 SHALL, in RUN, push ref_data into the FIFO when ref_valid=1.
REQ-018 SHALL, in RUN, pop the FIFO head and compare it with dut_data when dut_valid=1.
REQ-019 SHALL bypass the FIFO when the FIFO is empty and ref_valid and dut_valid are both 1: compare ref_data against dut_data directly, leaving the FIFO empty.
REQ-020 SHALL treat a push while full with a simultaneous pop as legal, leaving the occupancy unchanged.
REQ-021 SHALL treat a push while full without a pop as overflow: drop the sample, set ovf and fail, and go to HALT.
REQ-022 SHALL treat dut_valid=1 with the FIFO empty and no bypass as underflow: set ovf and fail, and go to HALT.
REQ-023 SHALL register the compare result, with 1-cycle latency: mismatch_cnt, first_* and fail update on the edge after the dut_valid sample.
REQ-024 SHALL increment mismatch_cnt on each mismatch and saturate it at 16'hFFFF without wrapping.
REQ-025 SHALL load first_idx/first_ref/first_dut only on the first mismatch of a run, with first_idx = the 0-based compared-sample index.
REQ-026 SHALL, in DONE, set pass=1 if mismatch_cnt==0 and ovf==0, otherwise set fail=1; pass and fail are never both 1.
REQ-027 SHALL ignore ref_valid and dut_valid outside RUN, and ignore start while in RUN.

Reset
REQ-028 SHALL, on rst, go to IDLE, empty the FIFO, and drive busy, pass, fail, ovf, mismatch_cnt, first_idx, first_ref and first_dut to 0.
REQ-029 SHALL abort a run on rst mid-RUN without producing a verdict.

Configuration
REQ-030 SHALL, with OUTPUT_COMPARE_XMASK_EN defined, mask reference bits that are x/z, so only known reference bits are compared 4-state against dut_data.
REQ-031 SHALL, without OUTPUT_COMPARE_XMASK_EN, use full 4-state case inequality on all W bits, so an x or z on either side that does not match exactly is a mismatch.

Structure
REQ-032 SHALL take the FSM state enum (IDLE, RUN, HALT, DONE) and the 16-bit counter width constant from the shared package cmp_pkg.
REQ-033 SHALL place the FIFO in the sub-module cmp_fifo (parameters W and DEPTH; push/pop/full/empty/head ports).

Verification
REQ-034 SHALL cover: NSAMP=16, DUT delayed 2 cycles, identical data -> DONE, pass=1, mismatch_cnt=0.
REQ-035 SHALL cover: NSAMP=16, sample 5 with dut=8'h3C vs ref=8'h3D, stop_on_err=0 -> mismatch_cnt=1, first_idx=5, first_ref=8'h3D, first_dut=8'h3C, fail=1.
REQ-036 SHALL cover: DEPTH=4, five ref pushes with no dut_valid -> ovf=1, fail=1, HALT.
REQ-037 SHALL cover: ref=8'b0000_00x1 vs dut=8'h01 -> a mismatch without OUTPUT_COMPARE_XMASK_EN; no mismatch with it.
REQ-038 SHALL cover: 70000 forced mismatches -> mismatch_cnt holds 16'hFFFF.
REQ-039 SHALL cover: rst asserted mid-RUN, then start -> all outputs 0 after reset, and a clean new run passes.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared types and constants for the output_compare comparator and its FIFO.
package cmp_pkg;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      sat_inc = v;
    end else begin
      sat_inc = v + 16'd1;
    end
  endfunction

endpackage

// File: rtl/cmp_fifo.sv
// Reference alignment FIFO: holds reference samples until the DUT stream catches up.
// A push while full is accepted only together with a pop.
module cmp_fifo
  import cmp_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign full   = (r_cnt == FULL_CNT);
  assign empty  = (r_cnt == {(AW+1){1'b0}});
  assign head   = r_mem[r_rd_ptr];
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);

  // Sample storage; occupancy gates every read so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_cnt    <= {(AW+1){1'b0}};
    end else if (clr) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_cnt    <= {(AW+1){1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_ONE;
        2'b01:   r_cnt <= r_cnt - CNT_ONE;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/output_compare.sv
// Streaming comparator: aligns a reference stream to a DUT stream and reports a verdict.
// Build macro OUTPUT_COMPARE_XMASK_EN masks x/z reference bits out of the comparison.
module output_compare
  import cmp_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int NSAMP = 20000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop_on_err,
  input  logic             ref_valid,
  input  logic [W-1:0]     ref_data,
  input  logic             dut_valid,
  input  logic [W-1:0]     dut_data,
  output logic             busy,
  output logic             pass,
  output logic             fail,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] first_idx,
  output logic [W-1:0]     first_ref,
  output logic [W-1:0]     first_dut,
  output logic             ovf
);

  localparam int SW = $clog2(NSAMP + 1);
  localparam logic [SW-1:0] SMP_LAST = SW'(NSAMP);
  localparam logic [SW-1:0] SMP_ONE  = SW'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_busy;
  logic [SW-1:0]    r_smp;
  logic [SW-1:0]    w_smp_nxt;
  logic             r_mis;
  logic [CNT_W-1:0] r_mis_idx;
  logic [W-1:0]     r_mis_ref;
  logic [W-1:0]     r_mis_dut;
  logic [CNT_W-1:0] r_mis_cnt;
  logic [CNT_W-1:0] r_first_idx;
  logic [W-1:0]     r_first_ref;
  logic [W-1:0]     r_first_dut;
  logic             r_pass;
  logic             r_fail;
  logic             r_ovf;

  logic             w_run;
  logic             w_go;
  logic             w_full;
  logic             w_empty;
  logic [W-1:0]     w_head;
  logic             w_bypass;
  logic             w_push;
  logic             w_pop;
  logic             w_ovf_ev;
  logic             w_udf_ev;
  logic             w_cmp_v;
  logic [W-1:0]     w_cmp_ref;
  logic             w_mis;
  logic             w_last;

  function automatic logic is_mis(input logic [W-1:0] r, input logic [W-1:0] d);
`ifdef OUTPUT_COMPARE_XMASK_EN
    logic m;
    m = 1'b0;
    for (int i = 0; i < W; i++) begin
      if ((r[i] !== 1'bx) && (r[i] !== 1'bz) && (r[i] !== d[i])) begin
        m = 1'b1;
      end
    end
    return m;
`else
    return (r !== d);
`endif
  endfunction

  assign w_run     = (r_state == RUN);
  assign w_go      = start && !w_run;
  assign w_bypass  = w_run && w_empty && ref_valid && dut_valid;
  assign w_push    = w_run && ref_valid && !w_bypass && (!w_full || dut_valid);
  assign w_pop     = w_run && dut_valid && !w_empty;
  assign w_ovf_ev  = w_run && ref_valid && w_full && !dut_valid;
  assign w_udf_ev  = w_run && dut_valid && w_empty && !ref_valid;
  assign w_cmp_v   = w_bypass || w_pop;
  assign w_cmp_ref = w_bypass ? ref_data : w_head;
  assign w_mis     = w_cmp_v && is_mis(w_cmp_ref, dut_data);
  assign w_smp_nxt = r_smp + SMP_ONE;
  assign w_last    = w_cmp_v && (w_smp_nxt == SMP_LAST);

  cmp_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_go),
    .push  (w_push),
    .wdata (ref_data),
    .pop   (w_pop),
    .full  (w_full),
    .empty (w_empty),
    .head  (w_head)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state; a registered mismatch halts only when stop_on_err is set.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start) w_state_nxt = RUN;
        else       w_state_nxt = IDLE;
      end
      RUN: begin
        if (w_ovf_ev || w_udf_ev)     w_state_nxt = HALT;
        else if (r_mis && stop_on_err) w_state_nxt = HALT;
        else if (w_last)               w_state_nxt = DONE;
        else                           w_state_nxt = RUN;
      end
      HALT, DONE: begin
        if (start) w_state_nxt = RUN;
        else       w_state_nxt = r_state;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    w_busy = 1'b0;
    case (r_state)
      RUN:     w_busy = 1'b1;
      default: w_busy = 1'b0;
    endcase
  end

  // Compared-sample counter and the one-cycle compare result stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_smp     <= {SW{1'b0}};
      r_mis     <= 1'b0;
      r_mis_idx <= {CNT_W{1'b0}};
      r_mis_ref <= {W{1'b0}};
      r_mis_dut <= {W{1'b0}};
    end else if (w_go) begin
      r_smp     <= {SW{1'b0}};
      r_mis     <= 1'b0;
      r_mis_idx <= {CNT_W{1'b0}};
      r_mis_ref <= {W{1'b0}};
      r_mis_dut <= {W{1'b0}};
    end else begin
      if (w_cmp_v) begin
        r_smp <= w_smp_nxt;
      end
      r_mis     <= w_mis;
      r_mis_idx <= CNT_W'(r_smp);
      r_mis_ref <= w_cmp_ref;
      r_mis_dut <= dut_data;
    end
  end

  // Mismatch count and first-mismatch capture; a zero count marks the first one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mis_cnt   <= {CNT_W{1'b0}};
      r_first_idx <= {CNT_W{1'b0}};
      r_first_ref <= {W{1'b0}};
      r_first_dut <= {W{1'b0}};
    end else if (w_go) begin
      r_mis_cnt   <= {CNT_W{1'b0}};
      r_first_idx <= {CNT_W{1'b0}};
      r_first_ref <= {W{1'b0}};
      r_first_dut <= {W{1'b0}};
    end else if (r_mis) begin
      r_mis_cnt <= sat_inc(r_mis_cnt);
      if (r_mis_cnt == {CNT_W{1'b0}}) begin
        r_first_idx <= r_mis_idx;
        r_first_ref <= r_mis_ref;
        r_first_dut <= r_mis_dut;
      end
    end
  end

  // Sticky verdict; pass waits in DONE until the compare stage has drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pass <= 1'b0;
      r_fail <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_go) begin
      r_pass <= 1'b0;
      r_fail <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_ovf_ev || w_udf_ev) begin
        r_ovf  <= 1'b1;
        r_fail <= 1'b1;
      end else if (r_mis) begin
        r_fail <= 1'b1;
      end else if ((r_state == DONE) && !r_fail && !r_ovf &&
                   (r_mis_cnt == {CNT_W{1'b0}})) begin
        r_pass <= 1'b1;
      end
    end
  end

  assign busy         = w_busy;
  assign pass         = r_pass;
  assign fail         = r_fail;
  assign ovf          = r_ovf;
  assign mismatch_cnt = r_mis_cnt;
  assign first_idx    = r_first_idx;
  assign first_ref    = r_first_ref;
  assign first_dut    = r_first_dut;

endmodule

// File: tb/tb_output_compare.sv
// Scoreboard bench for output_compare: scenarios queue expected end-of-run results,
// monitors pop and compare whenever a run ends (busy falls).
module tb_output_compare;

  typedef struct {
    logic        busy, pass, fail, ovf;
    logic [15:0] cnt, idx;
    logic [7:0]  fref, fdut;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, stop_on_err, ref_valid, dut_valid;
  logic [7:0] ref_data, dut_data;
  logic       busy, pass, fail, ovf;
  logic [15:0] mismatch_cnt, first_idx;
  logic [7:0]  first_ref, first_dut;

  logic       b_start, b_stop, b_ref_valid, b_dut_valid;
  logic [7:0] b_ref_data, b_dut_data;
  logic       b_busy, b_pass, b_fail, b_ovf;
  logic [15:0] b_cnt, b_idx;
  logic [7:0]  b_fref, b_fdut;

  output_compare #(.W(8), .DEPTH(4), .NSAMP(16)) u_dut (
    .clk(clk), .rst(rst), .start(start), .stop_on_err(stop_on_err),
    .ref_valid(ref_valid), .ref_data(ref_data), .dut_valid(dut_valid), .dut_data(dut_data),
    .busy(busy), .pass(pass), .fail(fail), .mismatch_cnt(mismatch_cnt),
    .first_idx(first_idx), .first_ref(first_ref), .first_dut(first_dut), .ovf(ovf));

  output_compare #(.W(8), .DEPTH(4), .NSAMP(70000)) u_big (
    .clk(clk), .rst(rst), .start(b_start), .stop_on_err(b_stop),
    .ref_valid(b_ref_valid), .ref_data(b_ref_data), .dut_valid(b_dut_valid), .dut_data(b_dut_data),
    .busy(b_busy), .pass(b_pass), .fail(b_fail), .mismatch_cnt(b_cnt),
    .first_idx(b_idx), .first_ref(b_fref), .first_dut(b_fdut), .ovf(b_ovf));

  int n_chk = 0;
  int n_pass = 0;
  res_t  q_small[$];
  string t_small[$];
  res_t  q_big[$];
  string t_big[$];
  logic [7:0] ref_arr[16];
  logic [7:0] dut_arr[16];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic cmp_res(input string tag, input res_t a, input res_t e);
    chk({tag, ".busy"}, 16'(a.busy), 16'(e.busy));
    chk({tag, ".pass"}, 16'(a.pass), 16'(e.pass));
    chk({tag, ".fail"}, 16'(a.fail), 16'(e.fail));
    chk({tag, ".ovf"},  16'(a.ovf),  16'(e.ovf));
    chk({tag, ".mismatch_cnt"}, a.cnt, e.cnt);
    chk({tag, ".first_idx"}, a.idx, e.idx);
    chk({tag, ".first_ref"}, 16'(a.fref), 16'(e.fref));
    chk({tag, ".first_dut"}, 16'(a.fdut), 16'(e.fdut));
  endtask

  function automatic res_t mk(input logic bz, input logic p, input logic f, input logic o,
                              input logic [15:0] c, input logic [15:0] i,
                              input logic [7:0] r, input logic [7:0] d);
    res_t x;
    x.busy = bz; x.pass = p; x.fail = f; x.ovf = o;
    x.cnt = c; x.idx = i; x.fref = r; x.fdut = d;
    return x;
  endfunction

  function automatic res_t snap_small();
    return mk(busy, pass, fail, ovf, mismatch_cnt, first_idx, first_ref, first_dut);
  endfunction

  function automatic res_t snap_big();
    return mk(b_busy, b_pass, b_fail, b_ovf, b_cnt, b_idx, b_fref, b_fdut);
  endfunction

  // Expected mismatch rule for a single sample pair.
  function automatic logic exp_mis(input logic [7:0] r, input logic [7:0] d);
`ifdef OUTPUT_COMPARE_XMASK_EN
    logic m;
    m = 1'b0;
    for (int i = 0; i < 8; i++)
      if ((r[i] === 1'b0 || r[i] === 1'b1) && r[i] !== d[i]) m = 1'b1;
    return m;
`else
    return (r !== d);
`endif
  endfunction

  // Monitor for the NSAMP=16 instance: a run has ended when busy falls.
  logic mon_pb = 1'b0;
  always begin
    @(negedge clk);
    if (mon_pb && !busy) begin
      repeat (3) @(negedge clk);
      if (q_small.size() == 0) chk("sb_small_underrun", 16'(q_small.size()), 16'd1);
      else cmp_res(t_small.pop_front(), snap_small(), q_small.pop_front());
    end
    mon_pb = busy;
  end

  // Monitor for the NSAMP=70000 instance.
  logic mon_bb = 1'b0;
  always begin
    @(negedge clk);
    if (mon_bb && !b_busy) begin
      repeat (3) @(negedge clk);
      if (q_big.size() == 0) chk("sb_big_underrun", 16'(q_big.size()), 16'd1);
      else cmp_res(t_big.pop_front(), snap_big(), q_big.pop_front());
    end
    mon_bb = b_busy;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    ref_valid = 1'b0; dut_valid = 1'b0; ref_data = 8'h00; dut_data = 8'h00; start = 1'b0;
  endtask

  task automatic expect_small(input string tag, input res_t e);
    q_small.push_back(e); t_small.push_back(tag);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 200) begin tick(); n++; end
    if (busy) chk({tag, ".timeout"}, 16'(busy), 16'd0);
    repeat (6) tick();
  endtask

  task automatic fill_same();
    for (int i = 0; i < 16; i++) begin
      ref_arr[i] = 8'(i * 7 + 3);
      dut_arr[i] = 8'(i * 7 + 3);
    end
  endtask

  task automatic run_stream(input string tag, input int delay, input logic stop, input bit restart_mid);
    stop_on_err = stop;
    start = 1'b1; tick(); start = 1'b0;
    for (int t = 0; t < 16 + delay; t++) begin
      ref_valid = (t < 16);
      ref_data  = 8'h00;
      if (t < 16) ref_data = ref_arr[t];
      dut_valid = (t >= delay);
      dut_data  = 8'h00;
      if (t >= delay) dut_data = dut_arr[t - delay];
      start = restart_mid && (t == 8);
      tick();
    end
    idle_inputs();
    wait_idle(tag);
  endtask

  logic [7:0] xr;
  logic       m;

  initial begin
    rst = 1'b1; stop_on_err = 1'b0; idle_inputs();
    b_start = 1'b0; b_stop = 1'b0; b_ref_valid = 1'b1; b_dut_valid = 1'b1;
    b_ref_data = 8'h5A; b_dut_data = 8'hA5;
    repeat (3) tick();
    cmp_res("reset_small", snap_small(), mk(0, 0, 0, 0, 16'h0, 16'h0, 8'h00, 8'h00));
    cmp_res("reset_big",   snap_big(),   mk(0, 0, 0, 0, 16'h0, 16'h0, 8'h00, 8'h00));
    rst = 1'b0;
    tick();

    // Identical data, DUT two cycles late; a start pulse mid-run must be ignored.
    fill_same();
    expect_small("delay2", mk(0, 1, 0, 0, 16'h0, 16'h0, 8'h00, 8'h00));
    run_stream("delay2", 2, 1'b0, 1'b1);

    // DUT four cycles late: the FIFO runs full with simultaneous push and pop.
    expect_small("delay4_full", mk(0, 1, 0, 0, 16'h0, 16'h0, 8'h00, 8'h00));
    run_stream("delay4_full", 4, 1'b0, 1'b0);

    // Single mismatch at sample 5, run continues.
    fill_same(); ref_arr[5] = 8'h3D; dut_arr[5] = 8'h3C;
    expect_small("mis5", mk(0, 0, 1, 0, 16'd1, 16'd5, 8'h3D, 8'h3C));
    run_stream("mis5", 0, 1'b0, 1'b0);

    // Two mismatches, only the first is captured.
    fill_same(); ref_arr[2] = 8'h11; dut_arr[2] = 8'h22; dut_arr[9] = 8'h00;
    expect_small("mis2_9", mk(0, 0, 1, 0, 16'd2, 16'd2, 8'h11, 8'h22));
    run_stream("mis2_9", 1, 1'b0, 1'b0);

    // stop_on_err halts after the mismatch at sample 3; sample 6 is never compared.
    fill_same(); dut_arr[3] = 8'h19; dut_arr[6] = 8'h00;
    expect_small("stop_err", mk(0, 0, 1, 0, 16'd1, 16'd3, 8'h18, 8'h19));
    run_stream("stop_err", 0, 1'b1, 1'b0);

    // Overflow: five reference pushes into a 4-deep FIFO without any DUT sample.
    expect_small("overflow", mk(0, 0, 1, 1, 16'h0, 16'h0, 8'h00, 8'h00));
    start = 1'b1; tick(); start = 1'b0;
    for (int t = 0; t < 5; t++) begin ref_valid = 1'b1; ref_data = 8'(t); tick(); end
    idle_inputs();
    wait_idle("overflow");

    // Underflow: DUT sample with nothing to compare against.
    expect_small("underflow", mk(0, 0, 1, 1, 16'h0, 16'h0, 8'h00, 8'h00));
    start = 1'b1; tick(); start = 1'b0;
    dut_valid = 1'b1; dut_data = 8'h42; tick();
    idle_inputs();
    wait_idle("underflow");

    // Unknown reference bit against a known DUT value.
    fill_same(); xr = 8'b0000_00x1; ref_arr[0] = xr; dut_arr[0] = 8'h01;
    m = exp_mis(xr, 8'h01);
    expect_small("xbit", mk(0, !m, m, 0, m ? 16'd1 : 16'd0, 16'd0,
                            m ? xr : 8'h00, m ? 8'h01 : 8'h00));
    run_stream("xbit", 0, 1'b0, 1'b0);

    // Reset mid-run clears everything without a verdict, then a clean run passes.
    fill_same();
    expect_small("rst_mid", mk(0, 0, 0, 0, 16'h0, 16'h0, 8'h00, 8'h00));
    stop_on_err = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    for (int t = 0; t < 5; t++) begin
      ref_valid = 1'b1; dut_valid = 1'b1; ref_data = 8'h77; dut_data = 8'h00; tick();
    end
    idle_inputs();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    repeat (6) tick();
    expect_small("after_rst", mk(0, 1, 0, 0, 16'h0, 16'h0, 8'h00, 8'h00));
    run_stream("after_rst", 0, 1'b0, 1'b0);

    // Saturation: 70000 mismatching samples in one run.
    q_big.push_back(mk(0, 0, 1, 0, 16'hFFFF, 16'h0, 8'h5A, 8'hA5));
    t_big.push_back("saturate");
    b_start = 1'b1; tick(); b_start = 1'b0;
    begin
      int n;
      n = 0;
      while (b_busy && n < 71000) begin tick(); n++; end
      if (b_busy) chk("saturate.timeout", 16'(b_busy), 16'd0);
    end
    repeat (6) tick();

    chk("sb_drain", 16'(q_small.size() + q_big.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
